lfsr_rand: RTL and testbench

LFSR_RAND -- requirements
Module: lfsr_rand

---
 rtl/lfsr_rand.sv | 114 +++++++++++
 tb/tb_lfsr_rand.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand.sv
// lfsr_rand: Galois LFSR random source with a rejection-sampled ranged pick.
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous active-high reset
//   shiftEn   : advance the LFSR one step this cycle
//   seedLoad  : load seedVal (zero maps to SEED) into the LFSR
//   seedVal   : seed value
//   req       : request one ranged pick (ignored while busy)
//   outSeq    : low OUT_W bits of the LFSR state
//   busy      : high while a draw is in progress
//   pickValid : one-cycle pulse when pick updates
//   pick      : last ranged value, 0..RANGE-1
module lfsr_rand #(
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int unsigned       OUT_W     = 10,
  parameter int unsigned       RANGE     = 9,
  parameter int unsigned       MAX_TRIES = 8,
  localparam int unsigned      IDX_W     = $clog2(RANGE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shiftEn,
  input  logic              seedLoad,
  input  logic [LFSR_W-1:0] seedVal,
  input  logic              req,
  output logic [OUT_W-1:0]  outSeq,
  output logic              busy,
  output logic              pickValid,
  output logic [IDX_W-1:0]  pick
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [IDX_W:0]   RANGE_X  = (IDX_W+1)'(RANGE);
  // Only used when the candidate is >= RANGE, so RANGE < 2^IDX_W there.
  localparam logic [IDX_W-1:0] RANGE_LO = IDX_W'(RANGE);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic {IDLE, DRAW} fsm_t;

  fsm_t              fsm, fsm_nxt;
  logic [LFSR_W-1:0] state, state_nxt;
  logic [TRY_W-1:0]  tries, tries_nxt;
  logic [IDX_W-1:0]  pick_nxt;
  logic              valid_nxt;
  logic [IDX_W-1:0]  cand;

  // One Galois step; the state can never reach zero from a nonzero value.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  assign cand   = state[IDX_W-1:0];
  assign outSeq = state[OUT_W-1:0];
  assign busy   = (fsm == DRAW);

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= IDLE;
      state     <= SEED;
      tries     <= '0;
      pick      <= '0;
      pickValid <= 1'b0;
    end else begin
      fsm       <= fsm_nxt;
      state     <= state_nxt;
      tries     <= tries_nxt;
      pick      <= pick_nxt;
      pickValid <= valid_nxt;
    end
  end

  // Next-state: draw FSM, try counter, pick, LFSR update
  always_comb begin
    fsm_nxt   = fsm;
    tries_nxt = tries;
    pick_nxt  = pick;
    valid_nxt = 1'b0;
    state_nxt = state;

    case (fsm)
      IDLE: begin
        if (req) begin
          fsm_nxt   = DRAW;
          tries_nxt = '0;
        end
      end
      DRAW: begin
        if ({1'b0, cand} < RANGE_X) begin
          pick_nxt  = cand;
          valid_nxt = 1'b1;
          fsm_nxt   = IDLE;
        end else if (tries < LAST_TRY) begin
          tries_nxt = tries + TRY_W'(1);
        end else begin
          // Candidate < 2^IDX_W <= 2*RANGE, so folding once lands in range.
          pick_nxt  = cand - RANGE_LO;
          valid_nxt = 1'b1;
          fsm_nxt   = IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase

    // Load beats step; a draw steps exactly once per cycle regardless of shiftEn.
    if (seedLoad) begin
      state_nxt = (seedVal == '0) ? SEED : seedVal;
    end else if (shiftEn || (fsm == DRAW)) begin
      state_nxt = lfsr_step(state);
    end
  end

endmodule

// File: tb/tb_lfsr_rand.sv
// tb_lfsr_rand: randomized self-checking bench for lfsr_rand with an
// in-bench behavioural model plus hand-computed literal expectations.
module tb_lfsr_rand;

  localparam int TAPS_I  = 'hB400;
  localparam int SEED_I  = 'hACE1;
  localparam int RNG     = 9;
  localparam int TRIES   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        shift_en = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_val = '0;
  logic        req = 1'b0;
  logic [9:0]  out_seq;
  logic        busy;
  logic        pick_valid;
  logic [3:0]  pick;

  int passed = 0;
  int total  = 0;
  int picks  = 0;

  // Behavioural model: the LFSR value as an integer, plus the draw in flight
  int m_state = SEED_I;
  bit m_drawing = 0;
  int m_attempts = 0;
  int m_pick = 0;
  bit m_valid = 0;

  lfsr_rand dut (
    .clk(clk), .rst(rst), .shiftEn(shift_en), .seedLoad(seed_load),
    .seedVal(seed_val), .req(req), .outSeq(out_seq), .busy(busy),
    .pickValid(pick_valid), .pick(pick)
  );

  always #5 clk = ~clk;

  function automatic int step(input int s);
    return (s / 2) ^ (((s % 2) == 1) ? TAPS_I : 0);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Model update
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = SEED_I; m_drawing = 0; m_attempts = 0; m_pick = 0; m_valid = 0;
    end else begin
      int cand;
      bit was_drawing;
      cand = m_state % 16;
      was_drawing = m_drawing;
      m_valid = 0;
      if (m_drawing) begin
        m_attempts++;
        if (cand < RNG) begin
          m_pick = cand; m_valid = 1; m_drawing = 0;
        end else if (m_attempts == TRIES) begin
          m_pick = cand - RNG; m_valid = 1; m_drawing = 0;
        end
      end else if (req) begin
        m_drawing = 1; m_attempts = 0;
      end
      if (seed_load) m_state = (seed_val == 0) ? SEED_I : int'(seed_val);
      else if (shift_en || was_drawing) m_state = step(m_state);
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("outSeq", int'(out_seq), m_state % 1024);
    chk("busy", int'(busy), int'(m_drawing));
    chk("pickValid", int'(pick_valid), int'(m_valid));
    chk("pick", int'(pick), m_pick);
    if (pick_valid) begin
      picks++;
      chk("pick_in_range", int'(pick < 4'(RNG)), 1);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int s, t, exp_pick;
    bit found;

    // Reset and first steps with shiftEn held high
    shift_en = 1'b1;
    tick(); tick();
    chk("rst_outSeq", int'(out_seq), 'h0E1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pickValid", int'(pick_valid), 0);
    chk("rst_pick", int'(pick), 0);
    rst = 1'b0;
    tick(); chk("step1", int'(out_seq), 'h270);
    tick(); tick(); chk("step3", int'(out_seq), 'h09C);
    tick(); tick(); chk("step5", int'(out_seq), 'h227);
    chk("model_step5", m_state, 'h0E27);

    // Hold when idle
    shift_en = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("hold10", int'(out_seq), 'h0E1);

    // Seed loading
    seed_load = 1'b1; seed_val = 16'h0000;
    tick(); chk("seed_zero", int'(out_seq), 'h0E1);
    chk("model_seed_zero", m_state, 'hACE1);
    seed_val = 16'h1234; shift_en = 1'b1;
    tick(); chk("seed_wins", int'(out_seq), 'h234);
    seed_load = 1'b0; shift_en = 1'b0;

    // Single-attempt draws from ACE1
    do_reset();
    req = 1'b1; tick(); req = 1'b0;
    chk("draw1_busy", int'(busy), 1);
    tick();
    chk("draw1_valid", int'(pick_valid), 1);
    chk("draw1_pick", int'(pick), 1);
    chk("draw1_busy_off", int'(busy), 0);
    chk("draw1_state", int'(out_seq), 'h270);
    req = 1'b1; tick(); req = 1'b0;
    tick();
    chk("draw2_pick", int'(pick), 0);

    // One rejection from seed 000F
    seed_load = 1'b1; seed_val = 16'h000F; tick(); seed_load = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    tick();
    chk("rej_busy", int'(busy), 1);
    chk("rej_novalid", int'(pick_valid), 0);
    tick();
    chk("rej_valid", int'(pick_valid), 1);
    chk("rej_pick", int'(pick), 7);

    // Reset in the middle of a draw
    seed_load = 1'b1; seed_val = 16'h000F; tick(); seed_load = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    tick();
    rst = 1'b1; #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_outSeq", int'(out_seq), 'h0E1);
    rst = 1'b0;
    tick();
    chk("abort_novalid", int'(pick_valid), 0);

    // Exhausted draw: find a seed whose next TRIES candidates all reject
    found = 0; exp_pick = 0; s = 0;
    for (int k = 1; k < 65536 && !found; k++) begin
      bit ok;
      ok = 1; t = k;
      for (int a = 0; a < TRIES; a++) begin
        if (t % 16 < RNG) ok = 0;
        if (a == TRIES - 1) exp_pick = t % 16 - RNG;
        t = step(t);
      end
      if (ok) begin found = 1; s = k; end
    end
    chk("exhaust_seed_found", int'(found), 1);
    seed_load = 1'b1; seed_val = 16'(s); tick(); seed_load = 1'b0;
    req = 1'b1; tick(); req = 1'b0;
    repeat (TRIES - 1) tick();
    chk("exhaust_busy", int'(busy), 1);
    tick();
    chk("exhaust_valid", int'(pick_valid), 1);
    chk("exhaust_pick", int'(pick), exp_pick);

    // Full period with shiftEn high and random requests riding along
    do_reset();
    shift_en = 1'b1;
    picks = 0;
    for (int i = 0; i < 65535; i++) begin
      req = ($urandom % 4) != 0;
      tick();
    end
    req = 1'b0;
    chk("period_outSeq", int'(out_seq), 'h0E1);
    chk("period_model", m_state, 'hACE1);
    chk("picks_ge_10000", int'(picks >= 10000), 1);

    // Random mix of loads, shifts and requests
    for (int i = 0; i < 3000; i++) begin
      req = $urandom % 2;
      shift_en = $urandom % 2;
      seed_load = ($urandom % 8) == 0;
      seed_val = (($urandom % 4) == 0) ? 16'h0 : 16'($urandom);
      tick();
    end
    req = 1'b0; shift_en = 1'b0; seed_load = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
